// File: rtl/gcd_pkg.sv
// Shared types for the gcd job issuer.
// States, response codes and default widths.
package gcd_pkg;

  localparam int GCD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    ISSUE,
    WAIT_DONE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_FAIL    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/gcd_job_issuer_sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gcd_job_issuer.sv
// Drives one gcd core through a start/done job
// and reports PASS/FAIL/TIMEOUT per job.
module gcd_job_issuer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [W-1:0]     job_opa,
  input  logic [W-1:0]     job_opb,
  input  logic [W-1:0]     job_expect,
  output logic [W-1:0]     gcd_opa,
  output logic [W-1:0]     gcd_opb,
  output logic             gcd_start,
  input  logic             gcd_done,
  input  logic [W-1:0]     gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic             busy
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO_LAST = WCW'(TIMEOUT - 1);

  state_t         r_state;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_exp;
  logic           r_start;
  logic           r_done_q;
  logic           r_blank;
  logic [WCW-1:0] r_wait;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_result;
  logic [1:0]     r_rsp_status;
  logic           r_job_ready;

  logic w_edge;
  logic w_match;
  logic w_tmo;
  logic w_pass_inc;
  logic w_fail_inc;

  assign w_edge  = gcd_done & ~r_done_q;
  assign w_match = (gcd_result == r_exp);
  assign w_tmo   = (r_state == WAIT_DONE) &&
                   !w_edge && (r_wait == TMO_LAST);
  assign w_pass_inc = (r_state == CAPTURE) && w_match;
  assign w_fail_inc = (r_state == CAPTURE) && !w_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_opa        <= '0;
      r_opb        <= '0;
      r_exp        <= '0;
      r_start      <= 1'b0;
      r_done_q     <= 1'b0;
      r_blank      <= 1'b0;
      r_wait       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= ST_PASS;
      r_job_ready  <= 1'b0;
    end else begin
      // sampled in every state so a done held through blanking is no edge
      r_done_q <= gcd_done;
      unique case (r_state)
        IDLE: begin
          r_job_ready <= 1'b1;
          if (job_valid && r_job_ready) begin
            r_opa       <= job_opa;
            r_opb       <= job_opb;
            r_exp       <= job_expect;
            r_job_ready <= 1'b0;
            r_state     <= GAP;
          end
        end
        GAP: begin
          r_start <= 1'b1;
          r_wait  <= '0;
          r_blank <= 1'b0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_blank <= 1'b1;
          if (r_blank) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (w_edge) begin
            r_state <= CAPTURE;
          end else if (w_tmo) begin
            r_start      <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_status <= ST_TIMEOUT;
            r_state      <= RESP;
          end else begin
            r_wait <= r_wait + WCW'(1);
          end
        end
        CAPTURE: begin
          r_start      <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_rsp_result <= gcd_result;
          r_rsp_status <= w_match ? ST_PASS : ST_FAIL;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_job_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pass_inc),
    .count (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail (
    .clk   (clk),
    .reset (reset),
    .inc   (w_fail_inc),
    .count (fail_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .inc   (w_tmo),
    .count (tmo_cnt)
  );

  assign job_ready  = r_job_ready;
  assign gcd_opa    = r_opa;
  assign gcd_opb    = r_opb;
  assign gcd_start  = r_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_status = r_rsp_status;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_gcd_job_issuer.sv
// Directed bench: issuer paired with a behavioural
// gcd core whose done latency is programmable.
module tb_gcd_job_issuer;
  import gcd_pkg::*;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [W-1:0]  job_opa;
  logic [W-1:0]  job_opb;
  logic [W-1:0]  job_expect;
  logic [W-1:0]  gcd_opa;
  logic [W-1:0]  gcd_opb;
  logic          gcd_start;
  logic          gcd_done;
  logic [W-1:0]  gcd_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [1:0]    rsp_status;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_job_issuer #(
    .W       (W),
    .TIMEOUT (64),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_opa    (job_opa),
    .job_opb    (job_opb),
    .job_expect (job_expect),
    .gcd_opa    (gcd_opa),
    .gcd_opb    (gcd_opb),
    .gcd_start  (gcd_start),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .tmo_cnt    (tmo_cnt),
    .busy       (busy)
  );

  // behavioural core
  int   m_lat   = 3;
  bit   m_hold  = 1'b0;
  bit   m_never = 1'b0;
  logic m_sq;
  logic m_act;
  int   m_cnt;

  function automatic logic [W-1:0] gcd_f(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    for (int k = 0; k < 200; k++) begin
      if (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      gcd_done   <= 1'b0;
      gcd_result <= '0;
      m_sq       <= 1'b0;
      m_act      <= 1'b0;
      m_cnt      <= 0;
    end else begin
      m_sq <= gcd_start;
      if (gcd_start && !m_sq) begin
        m_act <= 1'b1;
        m_cnt <= 1;
      end else if (m_act) begin
        m_cnt <= m_cnt + 1;
        if (m_hold && m_cnt == 3) gcd_done <= 1'b0;
        if (!m_never && m_cnt == m_lat) begin
          gcd_done   <= 1'b1;
          gcd_result <= gcd_f(gcd_opa, gcd_opb);
          m_act      <= 1'b0;
        end
      end
      if (!gcd_start && m_sq && !m_hold) gcd_done <= 1'b0;
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic run_job(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] e,
    input  logic [W-1:0] xr,
    input  logic [1:0]   xs,
    input  int           stall,
    input  int           xpc,
    output int           lat
  );
    int n;
    n = 0;
    while (!job_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("job_ready", job_ready, 1);
    job_opa    = a;
    job_opb    = b;
    job_expect = e;
    job_valid  = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    check("gap_start", gcd_start, 0);
    check("gap_opa", gcd_opa, a);
    check("gap_opb", gcd_opb, b);
    check("gap_busy", busy, 1);
    @(posedge clk); #1;
    check("issue_start", gcd_start, 1);
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, xr);
    check("rsp_status", rsp_status, xs);
    check("rsp_start", gcd_start, 0);
    lat = n;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, xr);
      check("stall_status", rsp_status, xs);
      check("stall_jready", job_ready, 0);
      check("stall_pass", pass_cnt, xpc);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
  endtask

  int lat;
  int pexp;

  initial begin
    reset      = 1'b1;
    job_valid  = 1'b0;
    job_opa    = '0;
    job_opb    = '0;
    job_expect = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_jready", job_ready, 0);
    check("rst_start", gcd_start, 0);
    check("rst_opa", gcd_opa, 0);
    check("rst_opb", gcd_opb, 0);
    check("rst_rvalid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_status", rsp_status, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_tmo", tmo_cnt, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_jready", job_ready, 1);

    // pass job, latency 3
    run_job(102, 12, 6, 6, ST_PASS, 0, 0, lat);
    check("t1_lat", lat, 7);
    check("t1_pass", pass_cnt, 1);
    check("t1_fail", fail_cnt, 0);

    // wrong expectation
    run_job(18190, 13082, 3, 2, ST_FAIL, 0, 0, lat);
    check("t2_lat", lat, 7);
    check("t2_fail", fail_cnt, 1);
    check("t2_pass", pass_cnt, 1);

    // core never finishes
    m_never = 1'b1;
    run_job(5, 10, 5, 0, ST_TIMEOUT, 0, 0, lat);
    check("t3_lat", lat, 67);
    check("t3_tmo", tmo_cnt, 1);
    check("t3_pass", pass_cnt, 1);

    // response back-pressure
    m_never = 1'b0;
    run_job(48, 18, 6, 6, ST_PASS, 5, 2, lat);
    check("t4_pass", pass_cnt, 2);
    check("t4_fail", fail_cnt, 1);

    // back-to-back, done left high between jobs
    m_hold = 1'b1;
    m_lat  = 6;
    run_job(102, 12, 6, 6, ST_PASS, 0, 0, lat);
    check("t5a_lat", lat, 10);
    run_job(18190, 13082, 2, 2, ST_PASS, 0, 0, lat);
    check("t5b_lat", lat, 10);
    run_job(82066, 36915, 1, 1, ST_PASS, 0, 0, lat);
    check("t5c_lat", lat, 10);
    check("t5_pass_sat", pass_cnt, 3);
    check("t5_fail", fail_cnt, 1);

    // reset while waiting on done
    m_hold  = 1'b0;
    m_never = 1'b1;
    job_opa    = 7;
    job_opb    = 14;
    job_expect = 7;
    job_valid  = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_busy_pre", busy, 1);
    check("t6_start_pre", gcd_start, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_start", gcd_start, 0);
    check("t6_busy", busy, 0);
    check("t6_rvalid", rsp_valid, 0);
    check("t6_pass", pass_cnt, 0);
    check("t6_fail", fail_cnt, 0);
    check("t6_tmo", tmo_cnt, 0);
    check("t6_jready", job_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_rsp", rsp_valid, 0);
    check("t6_jready_on", job_ready, 1);

    // saturation after reset
    m_never = 1'b0;
    m_lat   = 2;
    run_job(9, 6, 3, 3, ST_PASS, 0, 0, lat);
    check("t6_lat", lat, 6);
    check("sat1", pass_cnt, 1);
    run_job(10, 4, 2, 2, ST_PASS, 0, 0, lat);
    check("sat2", pass_cnt, 2);
    run_job(21, 14, 7, 7, ST_PASS, 0, 0, lat);
    check("sat3", pass_cnt, 3);
    run_job(13, 13, 13, 13, ST_PASS, 0, 0, lat);
    check("sat4", pass_cnt, 3);
    run_job(100, 75, 25, 25, ST_PASS, 0, 0, lat);
    pexp = 3;
    check("sat5", pass_cnt, pexp);
    check("sat_fail", fail_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
